dual_rail_rx: RTL and testbench
===============================

DUAL_RAIL_RX -- requirements
Module: dual_rail_rx

Interface
REQ-001 SHALL have parameter: wd, 4, payload width in bits (minimum 1).
REQ-002 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth on incoming rails (minimum 2).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: rail_t  input  wd  true rails of the dual-rail channel, asynchronous to clk.
REQ-006 SHALL have port: rail_f  input  wd  false rails of the dual-rail channel, asynchronous to clk.
REQ-007 SHALL have port: ack  output  1  4-phase acknowledge back to the dual-rail sender.
REQ-008 SHALL have port: out_data  output  wd  decoded single-rail word.
REQ-009 SHALL have port: out_valid  output  1  out_data holds an undelivered word.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-011 SHALL have port: err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL decode per-bit rail pairs {t,f} as: 00 spacer, 10 logic 1, 01 logic 0, 11 illegal.
REQ-013 SHALL pass rail_t and rail_f through SYNC_STAGES flops before any use; the synchronized word is "complete" when every bit is 10 or 01, and "null" when every bit is 00.
REQ-014 SHALL register the synchronized word once more and treat it as "stable" when the synchronized and registered words are equal.
REQ-015 SHALL implement two states: WAIT_DATA (ack=0) and WAIT_NULL (ack=1); ack is a registered decode of state.
REQ-016 In WAIT_DATA, when complete, stable, no illegal bit, and the buffer is free (out_valid=0, or out_ready=1 in the same cycle), SHALL load out_data with the true rails, set out_valid, and move to WAIT_NULL on the same edge.
REQ-017 In WAIT_DATA, when complete and stable but the buffer is not free, SHALL hold state with ack=0 (back-pressure to the sender) and capture nothing.
REQ-018 In WAIT_NULL, when the synchronized word is null and stable, SHALL move to WAIT_DATA (ack returns to 0); otherwise it SHALL hold.
REQ-019 Latency SHALL be SYNC_STAGES+2 edges from a complete, stable rail change to out_valid=1 and ack=1 (4 edges at the defaults).
REQ-020 out_data SHALL remain constant while out_valid=1 and out_ready=0; out_valid SHALL clear on the accepting edge unless a new word is loaded on that same edge (REQ-016).
REQ-021 Any synchronized illegal bit (11), in either state, SHALL set err on the next edge; err SHALL stay set until reset, and no capture SHALL occur while any bit is illegal.
REQ-022 Partially valid words (a mix of spacer and valid bits) SHALL cause no action and no error.
REQ-023 The buffer SHALL hold one entry only; the channel throughput limit is one word per full 4-phase cycle.

Reset
REQ-024 When rst_n=0 at a clock edge, SHALL set: state WAIT_DATA, ack=0, out_valid=0, out_data=0, err=0, and all synchronizer and stability flops to 0.
REQ-025 Reset asserted mid-handshake SHALL abort the transfer; after release the block SHALL capture the next complete, stable word, which may be the still-present old word (the sender is responsible for re-synchronizing).

Structure
REQ-026 A shared package dr_pkg SHALL hold the state enumeration (WAIT_DATA, WAIT_NULL) and the rail-pair encoding constants (SPACER, RAIL_ONE, RAIL_ZERO, RAIL_ILLEGAL).
REQ-027 The synchronizer SHALL be a separate sub-module, sync_ff (parameters: width, stages), instantiated once for each rail vector.
REQ-028 The completion, null, and illegal detectors SHALL be combinational reductions inside dual_rail_rx.

Verification
REQ-029 Basic transfer: wd=4, rails t=1010, f=0101 from spacer, out_ready=1 -> out_valid and ack high 4 edges later, out_data=4'b1010; rails return to 00 -> ack low 4 edges later.
REQ-030 Back-pressure: out_ready=0 with a word held, second word t=0001, f=1110 presented -> ack stays 0 and out_data stays at the first word; out_ready=1 for one cycle -> first word accepted, second captured, out_data=4'b0001.
REQ-031 Skewed arrival: bits arrive one per cycle over 4 cycles -> no capture until all 4 bits are valid and stable; err stays 0.
REQ-032 Illegal pair: bit 2 driven 11 -> err=1 after SYNC_STAGES+1 edges, no out_valid; err still 1 after rails return to 00.
REQ-033 Reset mid-handshake: rst_n=0 while in WAIT_NULL with ack=1 -> on the next edge ack=0, out_valid=0, err=0, state WAIT_DATA.
REQ-034 Stream: 16 back-to-back 4-phase words with random values, out_ready toggling at random -> all 16 words delivered in order, none lost or duplicated.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared definitions for the dual-rail receiver: handshake states and the
// per-bit {true,false} rail-pair encodings.
package dr_pkg;

    // Four-phase handshake states; ack is high exactly while in WAIT_NULL
    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    // Rail-pair codes, written as {rail_t[i], rail_f[i]}
    localparam logic [1:0] SPACER       = 2'b00;
    localparam logic [1:0] RAIL_ONE     = 2'b10;
    localparam logic [1:0] RAIL_ZERO    = 2'b01;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a vector of asynchronous inputs.
// Each bit is synchronized independently; word coherence is handled by the
// stability check in the receiver, not here.
module sync_ff #(
    parameter int width  = 1,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage_q [stages];

    // Shift the asynchronous input through the flop chain, clearing all stages on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < stages; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int k = 1; k < stages; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q = stage_q[stages-1];

endmodule

// File: rtl/dual_rail_rx.sv
// Dual-rail (1-of-2 per bit) four-phase receiver. Synchronizes both rail
// vectors, waits for a complete and stable codeword, hands it to a
// one-entry single-rail output buffer, and acknowledges the sender. A
// null (all-spacer) phase must follow every word before the next one is
// accepted. Illegal 11 pairs raise a sticky error flag.
module dual_rail_rx
    import dr_pkg::*;
#(
    parameter int wd          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [wd-1:0] rail_t,
    input  logic [wd-1:0] rail_f,
    output logic          ack,
    output logic [wd-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err
);

    logic [wd-1:0] sync_t;
    logic [wd-1:0] sync_f;
    logic [wd-1:0] hold_t;
    logic [wd-1:0] hold_f;

    logic          all_valid;
    logic          all_null;
    logic          any_illegal;
    logic          stable;
    logic          buf_free;
    logic          load;

    state_t        state;

    // Bring the true rails into the clk domain
    sync_ff #(
        .width  (wd),
        .stages (SYNC_STAGES)
    ) u_sync_t (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rail_t),
        .q     (sync_t)
    );

    // Bring the false rails into the clk domain
    sync_ff #(
        .width  (wd),
        .stages (SYNC_STAGES)
    ) u_sync_f (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rail_f),
        .q     (sync_f)
    );

    // Keep a one-cycle-old copy of the synchronized word for the stability test
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_t <= '0;
            hold_f <= '0;
        end else begin
            hold_t <= sync_t;
            hold_f <= sync_f;
        end
    end

    // Classify every synchronized rail pair and reduce to word-level flags
    always_comb begin
        all_valid   = 1'b1;
        all_null    = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < wd; i++) begin
            case ({sync_t[i], sync_f[i]})
                SPACER: begin
                    all_valid = 1'b0;
                end
                RAIL_ONE, RAIL_ZERO: begin
                    all_null = 1'b0;
                end
                default: begin
                    any_illegal = 1'b1;
                    all_valid   = 1'b0;
                    all_null    = 1'b0;
                end
            endcase
        end
    end

    // A word is trusted only once it has been seen unchanged on two consecutive cycles
    assign stable   = (sync_t == hold_t) && (sync_f == hold_f);

    // The single buffer entry is free if empty or being drained this cycle
    assign buf_free = !out_valid || out_ready;

    assign load     = (state == WAIT_DATA) && all_valid && !any_illegal
                      && stable && buf_free;

    // Handshake FSM with registered ack, output buffer and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_DATA;
            ack       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (any_illegal) begin
                err <= 1'b1;
            end

            if (load) begin
                out_data  <= sync_t;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                WAIT_DATA: begin
                    if (load) begin
                        state <= WAIT_NULL;
                        ack   <= 1'b1;
                    end
                end
                WAIT_NULL: begin
                    if (all_null && stable) begin
                        state <= WAIT_DATA;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_DATA;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_rail_rx.sv
// Testbench for dual_rail_rx: directed handshake scenarios plus a short
// random stream, with a scoreboard queue checked by a separate monitor.
module tb_dual_rail_rx;

    localparam int WD   = 4;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WD-1:0] rail_t;
    logic [WD-1:0] rail_f;
    logic          ack;
    logic [WD-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    int            compared   = 0;
    int            mismatched = 0;
    logic [WD-1:0] expq [$];

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    dual_rail_rx #(
        .wd          (WD),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rail_t    (rail_t),
        .rail_f    (rail_f),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WD-1:0] t, input logic [WD-1:0] f);
        rail_t = t;
        rail_f = f;
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitAck(input logic level, input int budget, input bit rnd,
                           input string name);
        int n;
        n = 0;
        while (ack !== level && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (ack !== level) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: ack timeout, got %b, expected %b", name, ack, level);
        end
    endtask

    task automatic monitorLoop();
        logic [WD-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL scoreboard: got unexpected word %0h, expected none",
                             out_data);
                end else begin
                    exp = expq.pop_front();
                    checkOutput("scoreboard word", 32'(out_data), 32'(exp));
                end
            end
        end
    endtask

    // Main stimulus sequence; the monitor runs alongside it
    initial begin
        logic [WD-1:0] m;
        logic [WD-1:0] w;
        int            n;

        fork
            monitorLoop();
        join_none

        rst_n     = 1'b0;
        out_ready = 1'b0;
        applyStimulus('0, '0);
        stepEdges(2);
        checkOutput("reset ack", 32'(ack), 0);
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_data", 32'(out_data), 0);
        checkOutput("reset err", 32'(err), 0);
        rst_n = 1'b1;
        stepEdges(2);

        $display("[TB] basic transfer");
        out_ready = 1'b1;
        expq.push_back(4'b1010);
        applyStimulus(4'b1010, 4'b0101);
        stepEdges(3);
        checkOutput("basic ack early", 32'(ack), 0);
        checkOutput("basic valid early", 32'(out_valid), 0);
        stepEdges(1);
        checkOutput("basic ack", 32'(ack), 1);
        checkOutput("basic valid", 32'(out_valid), 1);
        checkOutput("basic data", 32'(out_data), 32'hA);
        applyStimulus('0, '0);
        stepEdges(3);
        checkOutput("basic ack held", 32'(ack), 1);
        stepEdges(1);
        checkOutput("basic ack release", 32'(ack), 0);

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        expq.push_back(4'b1100);
        applyStimulus(4'b1100, 4'b0011);
        waitAck(1'b1, 20, 1'b0, "bp first ack");
        applyStimulus('0, '0);
        waitAck(1'b0, 20, 1'b0, "bp first null");
        expq.push_back(4'b0001);
        applyStimulus(4'b0001, 4'b1110);
        stepEdges(8);
        checkOutput("bp ack held low", 32'(ack), 0);
        checkOutput("bp valid held", 32'(out_valid), 1);
        checkOutput("bp data held", 32'(out_data), 32'hC);
        out_ready = 1'b1;
        stepEdges(1);
        out_ready = 1'b0;
        checkOutput("bp second ack", 32'(ack), 1);
        checkOutput("bp second valid", 32'(out_valid), 1);
        checkOutput("bp second data", 32'(out_data), 32'h1);
        out_ready = 1'b1;
        applyStimulus('0, '0);
        waitAck(1'b0, 20, 1'b0, "bp second null");

        $display("[TB] skewed arrival");
        m = '0;
        for (int i = 0; i < WD; i++) begin
            m = {m[WD-2:0], 1'b1};
            if (i == WD - 1) expq.push_back(4'b0110);
            applyStimulus(4'b0110 & m, 4'b1001 & m);
            stepEdges(1);
            if (i < WD - 1) checkOutput("skew partial no ack", 32'(ack), 0);
        end
        stepEdges(2);
        checkOutput("skew valid early", 32'(out_valid), 0);
        stepEdges(1);
        checkOutput("skew ack", 32'(ack), 1);
        checkOutput("skew data", 32'(out_data), 32'h6);
        checkOutput("skew err", 32'(err), 0);
        applyStimulus('0, '0);
        waitAck(1'b0, 20, 1'b0, "skew null");

        $display("[TB] illegal pair");
        applyStimulus(4'b0100, 4'b0100);
        stepEdges(2);
        checkOutput("illegal err early", 32'(err), 0);
        stepEdges(1);
        checkOutput("illegal err", 32'(err), 1);
        stepEdges(3);
        checkOutput("illegal no valid", 32'(out_valid), 0);
        checkOutput("illegal no ack", 32'(ack), 0);
        applyStimulus('0, '0);
        stepEdges(6);
        checkOutput("illegal err sticky", 32'(err), 1);

        $display("[TB] reset mid-handshake");
        out_ready = 1'b0;
        applyStimulus(4'b1001, 4'b0110);
        stepEdges(4);
        checkOutput("rst pre ack", 32'(ack), 1);
        rst_n = 1'b0;
        stepEdges(1);
        checkOutput("rst ack", 32'(ack), 0);
        checkOutput("rst valid", 32'(out_valid), 0);
        checkOutput("rst err", 32'(err), 0);
        checkOutput("rst data", 32'(out_data), 0);
        stepEdges(1);
        rst_n = 1'b1;
        expq.push_back(4'b1001);
        out_ready = 1'b1;
        waitAck(1'b1, 20, 1'b0, "rst recapture");
        applyStimulus('0, '0);
        waitAck(1'b0, 20, 1'b0, "rst null");

        $display("[TB] random stream");
        for (int k = 0; k < 16; k++) begin
            w = WD'($urandom);
            expq.push_back(w);
            applyStimulus(w, ~w);
            waitAck(1'b1, 200, 1'b1, "stream ack");
            applyStimulus('0, '0);
            waitAck(1'b0, 200, 1'b1, "stream null");
        end
        out_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            stepEdges(1);
            n++;
        end
        stepEdges(2);
        checkOutput("stream drained", 32'(expq.size()), 0);
        checkOutput("stream valid clear", 32'(out_valid), 0);
        checkOutput("stream err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global safety net so the run cannot hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
